row_scheduler: RTL and testbench
================================

// Module: row_scheduler
// PURPOSE
// - Sequences the falling note rows of the lane display: game-state FSM, level-dependent scroll prescaler,
//   row advance, and row recycle with a fresh random cube pattern.
// - Drives the per-row Y position / pattern consumed by the lane renderers and the scoring block.
// - Takes the pattern source, the level switches and the game-over flag.
// PARAMETERS
// NUM_ROWS     4        number of falling row slots
// Y_W          10       row Y width, bits
// ROW_SPACING  94       initial Y gap between consecutive rows (row i starts at i*ROW_SPACING)
// Y_WRAP       376      Y at/after which a row is recycled to Y=0
// STEP         1        pixels added per scroll tick
// DIV_L1       1562500  clk cycles per tick, level 1
// DIV_L2       1041667  clk cycles per tick, level 2
// DIV_L3       781250   clk cycles per tick, level 3
// PORTS
// clk          in   1             system clock (50 MHz domain)
// reset        in   1             asynchronous, active-low reset
// start        in   1             start/restart button, level; rising edge detected internally
// stop         in   1             pause request, level
// level        in   2             00=L1, 01=L2, 1x=L3
// game_over    in   1             loss flag from scoring
// rand_pattern in   5             random cube mask, sampled on load/recycle
// state        out  2             00 IDLE, 01 LOAD, 10 RUN/PAUSE(see paused), 11 OVER
// paused       out  1             1 while in PAUSE
// scroll_tick  out  1             1-cycle pulse per row advance
// row_y        out  NUM_ROWS*Y_W  packed row Y, row i at [i*Y_W +: Y_W]
// row_pat      out  NUM_ROWS*5    packed cube masks, row i at [i*5 +: 5]
// row_valid    out  NUM_ROWS      row slot holds a live row
// spawn        out  1             1-cycle pulse when any row is (re)loaded
// spawn_idx    out  2             lowest row index loaded in that cycle
// BEHAVIOUR
// - Reset: state IDLE, paused 0, all row_y/row_pat/row_valid 0, scroll_tick/spawn 0, spawn_idx 0, prescaler 0.
// - FSM: IDLE --start rise--> LOAD; LOAD loads row k in its k-th cycle (row_y=k*ROW_SPACING, row_pat=rand_pattern,
//   valid=1, spawn=1, spawn_idx=k), NUM_ROWS cycles -> RUN; RUN --stop=1--> PAUSE; PAUSE --stop=0--> RUN;
//   RUN/PAUSE --game_over=1--> OVER (priority over stop); OVER --start rise--> LOAD. start rise in RUN/PAUSE ignored.
// - Prescaler: counts 0..div-1 in RUN only; frozen in PAUSE; cleared in IDLE/LOAD/OVER. scroll_tick=1 in the cycle
//   the count equals div-1 (count then wraps to 0). div selected from level; any level change clears the count that cycle.
// - Advance: rows update the cycle after scroll_tick: row_y += STEP. If old row_y+STEP >= Y_WRAP, row_y<=0 and
//   row_pat<=rand_pattern (same sample for all rows wrapping together), spawn=1, spawn_idx=lowest wrapping index.
// - Arithmetic in Y_W+1 bits, no overflow; Y_WRAP <= 2^Y_W - 1.
// - PAUSE/OVER: row_y/row_pat/row_valid hold. game_over arriving the cycle of scroll_tick: that advance is dropped.
// - Async reset mid-LOAD or mid-RUN returns everything to reset values immediately.
// CONFIGURATION
// - SCROLL_ACCEL_EN defined: 4-bit recycle counter; every 16 recycles accel step (0..8, saturating) increments;
//   div_eff = div - step*(div>>4), floor div/2. Step and counter cleared on level change and in LOAD.
// - SCROLL_ACCEL_EN undefined: div_eff = div constant; no counter logic.
// TESTING (bench params: DIV_L1=4, DIV_L2=3, DIV_L3=2, STEP=1, ROW_SPACING=4, Y_WRAP=16)
// - reset low then high, start rise -> 4 LOAD cycles, spawn_idx 0,1,2,3, row_y={12,8,4,0}, then state=RUN.
// - RUN level=00 -> scroll_tick every 4 clk; after 1 tick row_y={13,9,5,1}.
// - Row 3 at Y=15, tick -> row 3 Y=0, row_pat[3]=rand_pattern, spawn=1, spawn_idx=3.
// - stop=1 for 10 clk -> paused=1, no tick, row_y frozen; stop=0 -> tick resumes from held prescaler count.
// - level 00->1x mid-count -> count cleared, next tick 2 clk later, then every 2 clk.
// - game_over=1 same cycle as tick -> state OVER, row_y unchanged; start rise -> LOAD rows reinit.

Source files
------------

// File: rtl/row_scheduler.sv
// Falling-row sequencer: game FSM, level-dependent scroll prescaler, row advance and recycle.
// Optional build macro SCROLL_ACCEL_EN shortens the tick period as rows keep recycling.
module row_scheduler #(
  parameter int NUM_ROWS    = 4,
  parameter int Y_W         = 10,
  parameter int ROW_SPACING = 94,
  parameter int Y_WRAP      = 376,
  parameter int STEP        = 1,
  parameter int DIV_L1      = 1562500,
  parameter int DIV_L2      = 1041667,
  parameter int DIV_L3      = 781250
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic [1:0]                level,
  input  logic                      game_over,
  input  logic [4:0]                rand_pattern,
  output logic [1:0]                state,
  output logic                      paused,
  output logic                      scroll_tick,
  output logic [NUM_ROWS*Y_W-1:0]   row_y,
  output logic [NUM_ROWS*5-1:0]     row_pat,
  output logic [NUM_ROWS-1:0]       row_valid,
  output logic                      spawn,
  output logic [1:0]                spawn_idx
);

  localparam int DIV_MAX = (DIV_L1 > DIV_L2) ? ((DIV_L1 > DIV_L3) ? DIV_L1 : DIV_L3)
                                             : ((DIV_L2 > DIV_L3) ? DIV_L2 : DIV_L3);
  localparam int CNT_W   = $clog2(DIV_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               start_q;
  logic [1:0]         level_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         load_k_q, load_k_d;
  logic [Y_W-1:0]     y_q   [NUM_ROWS];
  logic [Y_W-1:0]     y_d   [NUM_ROWS];
  logic [4:0]         pat_q [NUM_ROWS];
  logic [4:0]         pat_d [NUM_ROWS];
  logic [NUM_ROWS-1:0] valid_q, valid_d;
  logic               spawn_q, spawn_d;
  logic [1:0]         idx_q, idx_d;

  logic               start_rise;
  logic               level_chg;
  logic               tick;
  logic               adv;
  logic [CNT_W-1:0]   div_base;
  logic [CNT_W-1:0]   div_eff;
  logic [Y_W:0]       sum;

  assign start_rise = start & ~start_q;
  assign level_chg  = (level != level_q);

  always_comb begin
    div_base = CNT_W'(DIV_L1);
    if (level[1])      div_base = CNT_W'(DIV_L3);
    else if (level[0]) div_base = CNT_W'(DIV_L2);
  end

`ifdef SCROLL_ACCEL_EN
  logic [3:0]       rec_cnt_q, rec_cnt_d;
  logic [3:0]       accel_q, accel_d;
  logic [CNT_W-1:0] accel_dec;

  // Each accel step removes div/16 from the period; step saturates at 8, so div_eff never drops below div/2.
  assign accel_dec = CNT_W'(accel_q) * (div_base >> 4);
  assign div_eff   = div_base - accel_dec;

  always_comb begin
    rec_cnt_d = rec_cnt_q;
    accel_d   = accel_q;
    if (level_chg || state_q == S_LOAD) begin
      rec_cnt_d = '0;
      accel_d   = '0;
    end else if (adv && spawn_d) begin
      rec_cnt_d = rec_cnt_q + 4'd1;
      if (rec_cnt_q == 4'd15 && accel_q < 4'd8) accel_d = accel_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rec_cnt_q <= '0;
      accel_q   <= '0;
    end else begin
      rec_cnt_q <= rec_cnt_d;
      accel_q   <= accel_d;
    end
  end
`else
  assign div_eff = div_base;
`endif

  // Prescaler runs only in RUN, holds in PAUSE, and restarts on any level change.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (level_chg) begin
          cnt_d = '0;
        end else if (cnt_q >= div_eff - CNT_W'(1)) begin
          tick  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PAUSE: if (level_chg) cnt_d = '0;
      default: cnt_d = '0;
    endcase
  end

  // A loss reported in the tick cycle wins: the advance is dropped.
  assign adv = tick & ~game_over;

  always_comb begin
    state_d  = state_q;
    load_k_d = '0;
    case (state_q)
      S_IDLE: if (start_rise) state_d = S_LOAD;
      S_LOAD: begin
        if (load_k_q == 2'(NUM_ROWS - 1)) state_d = S_RUN;
        else                              load_k_d = load_k_q + 2'd1;
      end
      S_RUN: begin
        if (game_over) state_d = S_OVER;
        else if (stop) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (game_over)  state_d = S_OVER;
        else if (!stop) state_d = S_RUN;
      end
      S_OVER:  if (start_rise) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    y_d     = y_q;
    pat_d   = pat_q;
    valid_d = valid_q;
    spawn_d = 1'b0;
    idx_d   = '0;
    sum     = '0;
    if (state_q == S_LOAD) begin
      if (load_k_q == 2'd0) valid_d = '0;
      y_d[load_k_q]     = Y_W'(int'(load_k_q) * ROW_SPACING);
      pat_d[load_k_q]   = rand_pattern;
      valid_d[load_k_q] = 1'b1;
      spawn_d           = 1'b1;
      idx_d             = load_k_q;
    end else if (adv) begin
      // Walk downward so the lowest wrapping row is the one reported in spawn_idx.
      for (int i = NUM_ROWS - 1; i >= 0; i--) begin
        if (valid_q[i]) begin
          sum = {1'b0, y_q[i]} + (Y_W+1)'(STEP);
          if (sum >= (Y_W+1)'(Y_WRAP)) begin
            y_d[i]   = '0;
            pat_d[i] = rand_pattern;
            spawn_d  = 1'b1;
            idx_d    = 2'(i);
          end else begin
            y_d[i] = sum[Y_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      level_q  <= 2'b00;
      cnt_q    <= '0;
      load_k_q <= '0;
      valid_q  <= '0;
      spawn_q  <= 1'b0;
      idx_q    <= '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
        y_q[i]   <= '0;
        pat_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      level_q  <= level;
      cnt_q    <= cnt_d;
      load_k_q <= load_k_d;
      valid_q  <= valid_d;
      spawn_q  <= spawn_d;
      idx_q    <= idx_d;
      for (int i = 0; i < NUM_ROWS; i++) begin
        y_q[i]   <= y_d[i];
        pat_q[i] <= pat_d[i];
      end
    end
  end

  always_comb begin
    state = 2'b00;
    case (state_q)
      S_LOAD:         state = 2'b01;
      S_RUN, S_PAUSE: state = 2'b10;
      S_OVER:         state = 2'b11;
      default:        state = 2'b00;
    endcase
  end

  assign paused      = (state_q == S_PAUSE);
  assign scroll_tick = tick;
  assign row_valid   = valid_q;
  assign spawn       = spawn_q;
  assign spawn_idx   = idx_q;

  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_pack
    assign row_y[g*Y_W +: Y_W] = y_q[g];
    assign row_pat[g*5 +: 5]   = pat_q[g];
  end

endmodule

// File: tb/tb_row_scheduler.sv
// Bench for row_scheduler: directed scenarios plus random play, checked cycle by cycle against a game model.
module tb_row_scheduler;

  localparam int NR = 4;
  localparam int YW = 10;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_OVER = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, stop, game_over;
  logic [1:0]        level;
  logic [4:0]        rand_pattern;
  logic [1:0]        state;
  logic              paused, scroll_tick, spawn;
  logic [NR*YW-1:0]  row_y;
  logic [NR*5-1:0]   row_pat;
  logic [NR-1:0]     row_valid;
  logic [1:0]        spawn_idx;

  int total = 0;
  int bad   = 0;
  int tick_seen = 0;
  logic [63:0] exp_q[$];

  // game model
  int m_mode, m_load, m_cnt, m_sidx;
  int m_y[NR];
  int m_pat[NR];
  bit m_valid[NR];
  bit m_spawn;
  bit m_prev_start;
  logic [1:0] m_prev_level;

  always #5 clk = ~clk;

  row_scheduler #(
    .NUM_ROWS(NR), .Y_W(YW), .ROW_SPACING(4), .Y_WRAP(16), .STEP(1),
    .DIV_L1(4), .DIV_L2(3), .DIV_L3(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .level(level),
    .game_over(game_over), .rand_pattern(rand_pattern), .state(state),
    .paused(paused), .scroll_tick(scroll_tick), .row_y(row_y), .row_pat(row_pat),
    .row_valid(row_valid), .spawn(spawn), .spawn_idx(spawn_idx)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int div_of(input logic [1:0] lv);
    if (lv[1]) return 2;
    if (lv[0]) return 3;
    return 4;
  endfunction

  function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
    logic [63:0] r;
    r = '0;
    r[0 +: YW]    = YW'(a0);
    r[YW +: YW]   = YW'(a1);
    r[2*YW +: YW] = YW'(a2);
    r[3*YW +: YW] = YW'(a3);
    return r;
  endfunction

  function automatic bit m_tick_now();
    return (m_mode == M_RUN) && (level == m_prev_level) && (m_cnt == div_of(level) - 1);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_load = 0; m_cnt = 0; m_spawn = 0; m_sidx = 0;
    m_prev_start = 0; m_prev_level = 2'b00;
    for (int i = 0; i < NR; i++) begin
      m_y[i] = 0; m_pat[i] = 0; m_valid[i] = 0;
    end
  endtask

  // Applies one clock edge of game rules to the model, using the inputs held during that cycle.
  task automatic model_step();
    bit rise, lchg, tk;
    rise = start && !m_prev_start;
    lchg = (level != m_prev_level);
    tk   = m_tick_now();
    m_spawn = 0;
    m_sidx  = 0;
    if (m_mode == M_LOAD) begin
      if (m_load == 0) for (int i = 0; i < NR; i++) m_valid[i] = 0;
      m_y[m_load]     = m_load * 4;
      m_pat[m_load]   = int'(rand_pattern);
      m_valid[m_load] = 1;
      m_spawn = 1;
      m_sidx  = m_load;
    end else if (tk && !game_over) begin
      for (int i = 0; i < NR; i++) begin
        if (m_valid[i]) begin
          if (m_y[i] + 1 >= 16) begin
            m_y[i] = 0;
            m_pat[i] = int'(rand_pattern);
            if (!m_spawn) begin
              m_spawn = 1;
              m_sidx  = i;
            end
          end else begin
            m_y[i] = m_y[i] + 1;
          end
        end
      end
    end
    case (m_mode)
      M_RUN:   m_cnt = (lchg || tk) ? 0 : m_cnt + 1;
      M_PAUSE: if (lchg) m_cnt = 0;
      default: m_cnt = 0;
    endcase
    case (m_mode)
      M_IDLE, M_OVER: if (rise) begin m_mode = M_LOAD; m_load = 0; end
      M_LOAD: if (m_load == NR - 1) m_mode = M_RUN; else m_load++;
      M_RUN: begin
        if (game_over) m_mode = M_OVER;
        else if (stop) m_mode = M_PAUSE;
      end
      M_PAUSE: begin
        if (game_over)  m_mode = M_OVER;
        else if (!stop) m_mode = M_RUN;
      end
      default: m_mode = M_IDLE;
    endcase
    m_prev_start = start;
    m_prev_level = level;
  endtask

  // One clock: compare DUT outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cycle();
    logic [63:0] e_y, e_pat, e_val, got;
    int sc;
    @(negedge clk);
    e_y = pack4(m_y[0], m_y[1], m_y[2], m_y[3]);
    e_pat = '0; e_val = '0;
    for (int i = 0; i < NR; i++) begin
      e_pat[i*5 +: 5] = 5'(m_pat[i]);
      e_val[i] = m_valid[i];
    end
    sc = (m_mode == M_PAUSE) ? 2 : (m_mode == M_OVER) ? 3 : m_mode;
    exp_q.push_back(64'(sc));
    exp_q.push_back(64'(m_mode == M_PAUSE));
    exp_q.push_back(64'(m_tick_now()));
    exp_q.push_back(e_y);
    exp_q.push_back(e_pat);
    exp_q.push_back(e_val);
    exp_q.push_back(64'(m_spawn));
    exp_q.push_back(64'(m_sidx));
    got = 64'(state);       check("state", got, exp_q.pop_front());
    got = 64'(paused);      check("paused", got, exp_q.pop_front());
    got = 64'(scroll_tick); check("scroll_tick", got, exp_q.pop_front());
    got = 64'(row_y);       check("row_y", got, exp_q.pop_front());
    got = 64'(row_pat);     check("row_pat", got, exp_q.pop_front());
    got = 64'(row_valid);   check("row_valid", got, exp_q.pop_front());
    got = 64'(spawn);       check("spawn", got, exp_q.pop_front());
    got = 64'(spawn_idx);   check("spawn_idx", got, exp_q.pop_front());
    if (scroll_tick) tick_seen++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 64'(state), 64'd0);
    check({tag, "_paused"}, 64'(paused), 64'd0);
    check({tag, "_tick"}, 64'(scroll_tick), 64'd0);
    check({tag, "_row_y"}, 64'(row_y), 64'd0);
    check({tag, "_row_pat"}, 64'(row_pat), 64'd0);
    check({tag, "_valid"}, 64'(row_valid), 64'd0);
    check({tag, "_spawn"}, 64'(spawn), 64'd0);
    check({tag, "_spawn_idx"}, 64'(spawn_idx), 64'd0);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1 check_reset_vals(tag);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [NR*YW-1:0] snap;
    int t0;
    bit found;
    reset = 1'b0; start = 1'b0; stop = 1'b0; game_over = 1'b0;
    level = 2'b00; rand_pattern = 5'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_vals("por");
    reset = 1'b1;

    // start and load
    repeat (2) cycle();
    start = 1'b1; rand_pattern = 5'h0a;
    cycle();
    check("load_state", 64'(state), 64'd1);
    for (int k = 0; k < NR; k++) begin
      rand_pattern = 5'(k + 3);
      cycle();
    end
    check("load_rows", 64'(row_y), pack4(0, 4, 8, 12));
    check("load_run", 64'(state), 64'd2);
    start = 1'b0;

    // first tick after four clocks at level 1
    t0 = tick_seen;
    repeat (4) cycle();
    check("tick1_count", 64'(tick_seen - t0), 64'd1);
    check("tick1_rows", 64'(row_y), pack4(1, 5, 9, 13));

    // three more ticks: top row wraps and takes the fresh pattern
    rand_pattern = 5'h15;
    repeat (12) cycle();
    check("wrap_rows", 64'(row_y), pack4(4, 8, 12, 0));
    check("wrap_pat", 64'(row_pat[15 +: 5]), 64'h15);
    check("wrap_spawn", 64'(spawn), 64'd1);
    check("wrap_idx", 64'(spawn_idx), 64'd3);

    // pause
    repeat (2) cycle();
    stop = 1'b1;
    cycle();
    snap = row_y; t0 = tick_seen;
    repeat (9) cycle();
    check("pause_flag", 64'(paused), 64'd1);
    check("pause_rows", 64'(row_y), 64'(snap));
    check("pause_ticks", 64'(tick_seen - t0), 64'd0);
    stop = 1'b0;
    repeat (6) cycle();

    // level change mid-count
    repeat (2) cycle();
    level = 2'b10;
    t0 = tick_seen;
    repeat (7) cycle();
    check("l3_ticks", 64'(tick_seen - t0), 64'd3);

    // loss in the tick cycle drops the advance
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (m_tick_now()) found = 1;
      else cycle();
    end
    check("find_tick", 64'(found), 64'd1);
    game_over = 1'b1; snap = row_y;
    cycle();
    game_over = 1'b0;
    check("over_state", 64'(state), 64'd3);
    check("over_rows", 64'(row_y), 64'(snap));
    repeat (3) cycle();
    start = 1'b1;
    cycle();
    repeat (NR) cycle();
    check("reload_rows", 64'(row_y), pack4(0, 4, 8, 12));
    start = 1'b0;
    repeat (5) cycle();

    // reset in the middle of RUN, then in the middle of LOAD
    async_reset("rst_run");
    start = 1'b1;
    repeat (3) cycle();
    async_reset("rst_load");
    start = 1'b0;

    // random play
    for (int n = 0; n < 3000; n++) begin
      rand_pattern = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) stop = ~stop;
      if ($urandom_range(0, 39) == 0) level = 2'($urandom_range(0, 3));
      game_over = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) start = ~start;
      cycle();
      if (n == 1500) async_reset("rst_rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
